// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven hour/minute editor that loads the timekeeper through a valid/ready handshake.
// Optional auto-repeat of a held inc/dec button is enabled by defining TIME_SET_REPEAT_EN.
module time_set_ctrl #(
    parameter int TIMEOUT_S     = 10,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic       set_ready,
    output logic       set_valid,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic       edit_active,
    output logic       edit_field,
    output logic [3:0] edit_Ht,
    output logic [3:0] edit_Hu,
    output logic [3:0] edit_Mt,
    output logic [3:0] edit_Mu
);

    typedef enum logic [1:0] {IDLE, EDIT_H, EDIT_M, COMMIT} state_t;

    state_t     state, state_next;
    logic [2:0] btn_prev;
    logic       mode_ev, inc_ev, dec_ev;
    logic       inc_go, dec_go;
    logic       editing;
    logic [5:0] idle_cnt, idle_cnt_next;
    logic [4:0] hour_next;
    logic [5:0] min_next;
    logic [2:0] min_tens;

    if (TIMEOUT_S < 1 || TIMEOUT_S > 63 || REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_param
        $error("time_set_ctrl: parameter out of range");
    end

    // Events are registered, so a press acts on the second clock edge after it is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev <= '0;
            mode_ev  <= 1'b0;
            inc_ev   <= 1'b0;
            dec_ev   <= 1'b0;
        end else begin
            btn_prev <= {btn_mode, btn_inc, btn_dec};
            mode_ev  <= btn_mode & ~btn_prev[2];
            inc_ev   <= btn_inc  & ~btn_prev[1];
            dec_ev   <= btn_dec  & ~btn_prev[0];
        end
    end

    assign editing = (state == EDIT_H) || (state == EDIT_M);

`ifdef TIME_SET_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    logic [RW-1:0] rpt_cnt;
    logic          rpt_hold, rpt_step;

    assign rpt_hold = editing && (btn_prev[1] ^ btn_prev[0]);
    assign rpt_step = rpt_hold && (rpt_cnt == RW'(REPEAT_DELAY));

    // After the first repeat the counter reloads so later steps come every REPEAT_PERIOD cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rpt_cnt <= '0;
        else if (!rpt_hold)
            rpt_cnt <= '0;
        else if (rpt_step)
            rpt_cnt <= RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
        else
            rpt_cnt <= rpt_cnt + 1'b1;
    end

    assign inc_go = (inc_ev & ~dec_ev) | (rpt_step & btn_prev[1]);
    assign dec_go = (dec_ev & ~inc_ev) | (rpt_step & btn_prev[0]);
`else
    assign inc_go = inc_ev & ~dec_ev;
    assign dec_go = dec_ev & ~inc_ev;
`endif

    always_comb begin
        state_next    = state;
        hour_next     = set_hour;
        min_next      = set_min;
        idle_cnt_next = idle_cnt;
        case (state)
            IDLE: begin
                if (mode_ev) begin
                    state_next    = EDIT_H;
                    hour_next     = cur_hour;
                    min_next      = cur_min;
                    idle_cnt_next = '0;
                end
            end
            EDIT_H, EDIT_M: begin
                if (mode_ev) begin
                    state_next    = (state == EDIT_H) ? EDIT_M : COMMIT;
                    idle_cnt_next = '0;
                end else if (inc_go || dec_go) begin
                    idle_cnt_next = '0;
                    if (state == EDIT_H) begin
                        if (inc_go)
                            hour_next = (set_hour == 5'd23) ? 5'd0 : set_hour + 5'd1;
                        else
                            hour_next = (set_hour == 5'd0) ? 5'd23 : set_hour - 5'd1;
                    end else begin
                        if (inc_go)
                            min_next = (set_min == 6'd59) ? 6'd0 : set_min + 6'd1;
                        else
                            min_next = (set_min == 6'd0) ? 6'd59 : set_min - 6'd1;
                    end
                end else if (tick_1hz) begin
                    if (idle_cnt == 6'(TIMEOUT_S - 1)) begin
                        state_next    = IDLE;
                        idle_cnt_next = '0;
                    end else begin
                        idle_cnt_next = idle_cnt + 6'd1;
                    end
                end
            end
            COMMIT: begin
                if (set_valid && set_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idle_cnt    <= '0;
            set_hour    <= '0;
            set_min     <= '0;
            set_valid   <= 1'b0;
            edit_active <= 1'b0;
            edit_field  <= 1'b0;
        end else begin
            state       <= state_next;
            idle_cnt    <= idle_cnt_next;
            set_hour    <= hour_next;
            set_min     <= min_next;
            set_valid   <= (state_next == COMMIT);
            edit_active <= (state_next != IDLE);
            edit_field  <= (state_next == EDIT_M);
        end
    end

    // Small-range binary to BCD by comparison against the tens boundaries.
    always_comb begin
        if (set_hour >= 5'd20) begin
            edit_Ht = 4'd2;
            edit_Hu = 4'(set_hour - 5'd20);
        end else if (set_hour >= 5'd10) begin
            edit_Ht = 4'd1;
            edit_Hu = 4'(set_hour - 5'd10);
        end else begin
            edit_Ht = 4'd0;
            edit_Hu = 4'(set_hour);
        end
        min_tens = 3'd0;
        for (int k = 1; k <= 5; k++) begin
            if (set_min >= 6'(10 * k))
                min_tens = 3'(k);
        end
        edit_Mt = {1'b0, min_tens};
        edit_Mu = 4'(set_min - 6'(10 * min_tens));
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: vector table, directed corner sequences and
// randomized traffic compared against an arithmetic reference model of the editor.
module tb_time_set_ctrl;

    localparam int TIMEOUT_S = 10;

    logic       clk, rst, tick_1hz, btn_mode, btn_inc, btn_dec, set_ready;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic       set_valid, edit_active, edit_field;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic [3:0] edit_Ht, edit_Hu, edit_Mt, edit_Mu;

    int errors = 0;
    int checks = 0;
    int xfer_count = 0;
    int valid_cycles = 0;

    // Reference model: phase 0 idle, 1 hour edit, 2 minute edit, 3 commit.
    int       m_phase, m_hour, m_min, m_ticks;
    bit [2:0] m_prev, m_pend;

    typedef struct {
        int mode, inc, dec, ready;
        int hour, min, valid, active, field;
    } vec_t;

    time_set_ctrl #(.TIMEOUT_S(TIMEOUT_S)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .cur_hour(cur_hour), .cur_min(cur_min), .set_ready(set_ready),
        .set_valid(set_valid), .set_hour(set_hour), .set_min(set_min),
        .edit_active(edit_active), .edit_field(edit_field),
        .edit_Ht(edit_Ht), .edit_Hu(edit_Hu), .edit_Mt(edit_Mt), .edit_Mu(edit_Mu)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model_reset();
        m_phase = 0; m_hour = 0; m_min = 0; m_ticks = 0;
        m_prev = '0; m_pend = '0;
    endfunction

    // Evaluated at a rising edge with the input levels held over the preceding cycle.
    function automatic void model_edge();
        bit [2:0] lvl;
        lvl = {btn_mode, btn_inc, btn_dec};
        case (m_phase)
            0: if (m_pend[2]) begin
                m_phase = 1; m_hour = int'(cur_hour); m_min = int'(cur_min); m_ticks = 0;
            end
            1, 2: begin
                if (m_pend[2]) begin
                    m_phase = m_phase + 1; m_ticks = 0;
                end else if (m_pend[1] ^ m_pend[0]) begin
                    if (m_phase == 1) m_hour = (m_hour + (m_pend[1] ? 1 : 23)) % 24;
                    else              m_min  = (m_min  + (m_pend[1] ? 1 : 59)) % 60;
                    m_ticks = 0;
                end else if (tick_1hz) begin
                    m_ticks = m_ticks + 1;
                    if (m_ticks == TIMEOUT_S) begin
                        m_phase = 0; m_ticks = 0;
                    end
                end
            end
            default: if (set_ready) m_phase = 0;
        endcase
        m_pend = lvl & ~m_prev;
        m_prev = lvl;
    endfunction

    function automatic logic [31:0] pack_dut();
        return {2'b0, set_valid, set_hour, set_min, edit_active, edit_field,
                edit_Ht, edit_Hu, edit_Mt, edit_Mu};
    endfunction

    function automatic logic [31:0] pack_model();
        return {2'b0, m_phase == 3, 5'(m_hour), 6'(m_min), m_phase != 0, m_phase == 2,
                4'(m_hour / 10), 4'(m_hour % 10), 4'(m_min / 10), 4'(m_min % 10)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int mode, input int inc, input int dec, input int tick);
        btn_mode = (mode != 0);
        btn_inc  = (inc != 0);
        btn_dec  = (dec != 0);
        tick_1hz = (tick != 0);
    endtask

    // One clock: tally handshake activity, advance the model, then sample 1 time unit after the edge.
    task automatic tickClock(input bit do_check, input string name);
        if (!rst && set_valid) valid_cycles++;
        if (!rst && set_valid && set_ready) xfer_count++;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        if (do_check) checkOutput(name, pack_dut(), pack_model());
    endtask

    task automatic press(input int which, input string name);
        applyStimulus(which == 0, which == 1, which == 2, 0);
        tickClock(1'b1, name);
        applyStimulus(0, 0, 0, 0);
        tickClock(1'b1, name);
    endtask

    task automatic tickSecond(input string name);
        applyStimulus(0, 0, 0, 1);
        tickClock(1'b1, name);
        applyStimulus(0, 0, 0, 0);
        tickClock(1'b1, name);
    endtask

    vec_t vecs [14];

    initial begin
        int busy;
        logic [4:0] held_h;
        logic [5:0] held_m;

        vecs = '{
            '{1, 0, 0, 0,  0,  0, 0, 0, 0},
            '{0, 0, 0, 0, 23, 59, 0, 1, 0},
            '{0, 1, 0, 0, 23, 59, 0, 1, 0},
            '{0, 0, 0, 0,  0, 59, 0, 1, 0},
            '{1, 0, 0, 0,  0, 59, 0, 1, 0},
            '{0, 0, 0, 0,  0, 59, 0, 1, 1},
            '{0, 1, 0, 0,  0, 59, 0, 1, 1},
            '{0, 0, 0, 0,  0,  0, 0, 1, 1},
            '{0, 1, 1, 0,  0,  0, 0, 1, 1},
            '{0, 0, 0, 0,  0,  0, 0, 1, 1},
            '{1, 0, 0, 1,  0,  0, 0, 1, 1},
            '{0, 0, 0, 1,  0,  0, 1, 1, 0},
            '{0, 0, 0, 1,  0,  0, 0, 0, 0},
            '{0, 1, 0, 0,  0,  0, 0, 0, 0}
        };

        rst = 1'b1; set_ready = 1'b0;
        cur_hour = 5'd0; cur_min = 6'd0;
        applyStimulus(0, 0, 0, 0);
        model_reset();
        #1;
        checkOutput("reset_state", pack_dut(), 32'h0);
        tickClock(1'b1, "reset_hold");
        tickClock(1'b1, "reset_hold");
        rst = 1'b0;

        // 23:59 wraps to 00:00 with no carry; simultaneous inc/dec is discarded.
        cur_hour = 5'd23; cur_min = 6'd59;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].mode, vecs[i].inc, vecs[i].dec, 0);
            set_ready = (vecs[i].ready != 0);
            tickClock(1'b0, "");
            checkOutput($sformatf("vec%0d", i),
                        {17'b0, set_hour, set_min, set_valid, edit_active, edit_field},
                        {17'b0, 5'(vecs[i].hour), 6'(vecs[i].min), vecs[i].valid != 0,
                         vecs[i].active != 0, vecs[i].field != 0});
        end
        applyStimulus(0, 0, 0, 0);
        set_ready = 1'b0;
        tickClock(1'b1, "vec_tail");

        // 00:00 hour decrement wraps to 23, then minute idle timeout on the 10th tick.
        cur_hour = 5'd0; cur_min = 6'd0;
        valid_cycles = 0;
        press(0, "wrap_enter");
        press(2, "wrap_dec");
        checkOutput("hour_dec_wrap", 32'(set_hour), 32'd23);
        press(0, "wrap_to_min");
        press(2, "wrap_min_dec");
        checkOutput("min_dec_wrap", 32'(set_min), 32'd59);
        for (int t = 0; t < TIMEOUT_S - 1; t++) tickSecond("timeout_wait");
        checkOutput("timeout_not_yet", 32'(edit_active), 32'd1);
        applyStimulus(0, 0, 0, 1);
        tickClock(1'b1, "timeout_tick");
        checkOutput("timeout_idle", 32'({edit_active, set_valid}), 32'd0);
        applyStimulus(0, 0, 0, 0);
        tickClock(1'b1, "timeout_after");
        checkOutput("timeout_no_valid", 32'(valid_cycles), 32'd0);

        // An inc event coinciding with the 9th tick restarts the timeout.
        cur_hour = 5'd13; cur_min = 6'd45;
        press(0, "restart_enter");
        press(0, "restart_min");
        for (int t = 0; t < 8; t++) tickSecond("restart_wait");
        applyStimulus(0, 1, 0, 0);
        tickClock(1'b1, "restart_inc");
        applyStimulus(0, 0, 0, 1);
        tickClock(1'b1, "restart_inc_tick");
        applyStimulus(0, 0, 0, 0);
        tickClock(1'b1, "restart_gap");
        for (int t = 0; t < TIMEOUT_S - 1; t++) tickSecond("restart_wait2");
        checkOutput("restart_still_active", 32'({edit_active, set_min}), {25'b0, 1'b1, 6'd46});
        tickSecond("restart_last");
        checkOutput("restart_timeout", 32'(edit_active), 32'd0);

        // 13:45 -> 15:55 via inc x2 and dec x50, ready already high at commit.
        cur_hour = 5'd13; cur_min = 6'd45;
        press(0, "main_enter");
        press(1, "main_inc");
        press(1, "main_inc");
        press(0, "main_to_min");
        for (int i = 0; i < 50; i++) press(2, "main_dec");
        xfer_count = 0;
        set_ready = 1'b1;
        press(0, "main_commit");
        for (int i = 0; i < 3; i++) tickClock(1'b1, "main_drain");
        set_ready = 1'b0;
        checkOutput("main_xfers", 32'(xfer_count), 32'd1);
        checkOutput("main_value", 32'({set_hour, set_min}), 32'({5'd15, 6'd55}));
        checkOutput("main_digits", 32'({edit_Ht, edit_Hu, edit_Mt, edit_Mu}), 32'h1555);

        // Commit stalled for 20 cycles while inc/mode are pulsed.
        cur_hour = 5'd7; cur_min = 6'd30;
        press(0, "stall_enter");
        press(0, "stall_min");
        press(0, "stall_commit");
        checkOutput("stall_valid", 32'(set_valid), 32'd1);
        held_h = set_hour; held_m = set_min;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(i % 4 == 2, i % 4 == 0, 0, i % 3 == 0);
            tickClock(1'b1, "stall_cycle");
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("stall_held", 32'({set_valid, set_hour, set_min}), 32'({1'b1, held_h, held_m}));
        xfer_count = 0;
        set_ready = 1'b1;
        tickClock(1'b1, "stall_release");
        set_ready = 1'b0;
        tickClock(1'b1, "stall_after");
        checkOutput("stall_single_xfer", 32'({xfer_count[3:0], edit_active, set_valid}), 32'({4'd1, 2'b00}));

        // Asynchronous reset while COMMIT is waiting.
        press(0, "rst_enter");
        press(0, "rst_min");
        press(0, "rst_commit");
        checkOutput("rst_pre_valid", 32'(set_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checkOutput("rst_async_valid", 32'(set_valid), 32'd0);
        checkOutput("rst_async_all", pack_dut(), pack_model());
        tickClock(1'b1, "rst_hold");
        tickClock(1'b1, "rst_hold");
        rst = 1'b0;
        tickClock(1'b1, "rst_release");

        // Randomized traffic alternating between busy and quiet button activity.
        for (int i = 0; i < 4000; i++) begin
            busy = ((i / 500) % 2 == 0) ? 1 : 0;
            cur_hour = 5'($urandom_range(0, 23));
            cur_min  = 6'($urandom_range(0, 59));
            applyStimulus(busy != 0 ? $urandom_range(0, 5) == 0 : $urandom_range(0, 60) == 0,
                          busy != 0 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 40) == 0,
                          busy != 0 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 40) == 0,
                          $urandom_range(0, 3) == 0);
            set_ready = ($urandom_range(0, 2) == 0);
            tickClock(1'b1, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
